// File: rtl/keccak_round_scheduler_if.sv
// Bundles the keccak round scheduler's control signals: block intake, round stepping and result hand-off.
// master = the scheduler itself; slave = the datapath and consumer side.
interface keccak_round_scheduler_if;
  logic        in_valid;
  logic        in_ready;
  logic        load;
  logic        stall;
  logic        round_en;
  logic [23:0] round_onehot;
  logic [4:0]  round_idx;
  logic        busy;
  logic        out_valid;
  logic        out_ack;

  modport master (
    input  in_valid, stall, out_ack,
    output in_ready, load, round_en, round_onehot, round_idx, busy, out_valid
  );

  modport slave (
    output in_valid, stall, out_ack,
    input  in_ready, load, round_en, round_onehot, round_idx, busy, out_valid
  );
endinterface

// File: rtl/keccak_round_scheduler.sv
// Sequences one Keccak permutation: accepts a block, steps NROUNDS rounds and holds the result until acknowledged.
// The current FSM state is exported on state_dbg.
module keccak_round_scheduler #(
  parameter int NROUNDS = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  keccak_round_scheduler_if.master  bus,
  output logic [1:0]                state_dbg
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Out-of-range NROUNDS is clamped so the one-hot can never leave the 24-bit field.
  localparam int NR = (NROUNDS < 1) ? 1 : ((NROUNDS > 24) ? 24 : NROUNDS);
  localparam logic [4:0] LAST_IDX = 5'(NR - 1);

  logic [1:0]  state_q;
  logic [23:0] onehot_q;
  logic [4:0]  idx_q;
  logic        load_w;
  logic        round_en_w;
  logic        last_round_w;

  // Handshakes: a block moves in when in_valid && in_ready in the same cycle (load);
  // a result moves out when out_valid && out_ack in the same cycle. Neither side may
  // withdraw a raised valid before it is taken; in_ready is high only in IDLE.
  assign load_w       = bus.in_valid && (state_q == IDLE) && !reset;
  assign round_en_w   = (state_q == ROUND) && !bus.stall && !reset;
  assign last_round_w = (idx_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      onehot_q <= '0;
      idx_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_w) begin
            state_q  <= ROUND;
            onehot_q <= 24'h000001;
            idx_q    <= '0;
          end
        end
        ROUND: begin
          if (round_en_w) begin
            if (last_round_w) begin
              state_q  <= DONE;
              onehot_q <= '0;
              idx_q    <= '0;
            end else begin
              onehot_q <= onehot_q << 1;
              idx_q    <= idx_q + 5'd1;
            end
          end
        end
        DONE: begin
          // in_valid is deliberately not looked at here; intake waits for IDLE.
          if (bus.out_ack) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q  <= IDLE;
          onehot_q <= '0;
          idx_q    <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.load         = load_w;
  assign bus.round_en     = round_en_w;
  assign bus.round_onehot = onehot_q;
  assign bus.round_idx    = idx_q;
  assign bus.busy         = (state_q == ROUND);
  assign bus.out_valid    = (state_q == DONE);
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_keccak_round_scheduler.sv
// Directed bench for keccak_round_scheduler: a 24-round instance and a 1-round instance share clock and reset.
module tb_keccak_round_scheduler;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic clk;
  logic reset;
  logic [1:0] state_a;
  logic [1:0] state_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] exp_q[$];

  keccak_round_scheduler_if ifa ();
  keccak_round_scheduler_if ifb ();

  keccak_round_scheduler #(.NROUNDS(24)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .bus       (ifa.master),
    .state_dbg (state_a)
  );

  keccak_round_scheduler #(.NROUNDS(1)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .bus       (ifb.master),
    .state_dbg (state_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  int load_cyc[$];

  initial begin
    reset = 1'b1;
    ifa.in_valid = 1'b0; ifa.stall = 1'b0; ifa.out_ack = 1'b0;
    ifb.in_valid = 1'b0; ifb.stall = 1'b0; ifb.out_ack = 1'b0;
    tick();
    tick();

    // load and round_en stay low while reset is high
    ifa.in_valid = 1'b1;
    settle();
    check("load_in_reset", 32'(ifa.load), 32'd0);
    check("round_en_in_reset", 32'(ifa.round_en), 32'd0);
    ifa.in_valid = 1'b0;
    reset = 1'b0;
    tick();

    // reset state
    check("rst_in_ready", 32'(ifa.in_ready), 32'd1);
    check("rst_onehot", 32'(ifa.round_onehot), 32'd0);
    check("rst_idx", 32'(ifa.round_idx), 32'd0);
    check("rst_busy", 32'(ifa.busy), 32'd0);
    check("rst_out_valid", 32'(ifa.out_valid), 32'd0);
    check("rst_state", 32'(state_a), 32'(S_IDLE));

    // basic permutation: load at T, rounds T+1..T+24, out_valid at T+25
    for (int k = 0; k < 24; k++) exp_q.push_back(24'h000001 << k);
    ifa.in_valid = 1'b1;
    settle();
    check("basic_load", 32'(ifa.load), 32'd1);
    tick();
    ifa.in_valid = 1'b0;
    settle();
    for (int k = 0; k < 24; k++) begin
      logic [23:0] e;
      e = exp_q.pop_front();
      check("basic_onehot", 32'(ifa.round_onehot), 32'(e));
      check("basic_idx", 32'(ifa.round_idx), k);
      check("basic_round_en", 32'(ifa.round_en), 32'd1);
      check("basic_busy", 32'(ifa.busy), 32'd1);
      check("basic_no_out_valid", 32'(ifa.out_valid), 32'd0);
      tick();
    end
    check("basic_out_valid", 32'(ifa.out_valid), 32'd1);
    check("basic_done_onehot", 32'(ifa.round_onehot), 32'd0);
    check("basic_done_idx", 32'(ifa.round_idx), 32'd0);
    check("basic_done_busy", 32'(ifa.busy), 32'd0);
    check("basic_done_round_en", 32'(ifa.round_en), 32'd0);
    check("basic_done_state", 32'(state_a), 32'(S_DONE));

    // backpressure: ack withheld for 5 DONE cycles with in_valid high
    ifa.in_valid = 1'b1;
    ifa.stall = 1'b1;
    settle();
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(ifa.out_valid), 32'd1);
      check("bp_in_ready", 32'(ifa.in_ready), 32'd0);
      check("bp_load", 32'(ifa.load), 32'd0);
      tick();
    end
    ifa.stall = 1'b0;
    ifa.out_ack = 1'b1;
    settle();
    check("bp_ack_no_load", 32'(ifa.load), 32'd0);
    tick();
    ifa.out_ack = 1'b0;
    settle();
    check("bp_idle_in_ready", 32'(ifa.in_ready), 32'd1);
    check("bp_idle_load", 32'(ifa.load), 32'd1);
    tick();
    ifa.in_valid = 1'b0;
    settle();

    // stall at round 10 for 3 cycles; out_valid comes 3 cycles late (load + 28)
    for (int i = 0; i < 10; i++) tick();
    check("stall_pre_idx", 32'(ifa.round_idx), 32'd10);
    ifa.stall = 1'b1;
    settle();
    for (int i = 0; i < 3; i++) begin
      check("stall_onehot", 32'(ifa.round_onehot), 32'h000400);
      check("stall_round_en", 32'(ifa.round_en), 32'd0);
      check("stall_busy", 32'(ifa.busy), 32'd1);
      tick();
    end
    ifa.stall = 1'b0;
    settle();
    check("stall_post_idx", 32'(ifa.round_idx), 32'd10);
    for (int i = 0; i < 14; i++) begin
      check("stall_no_out_valid", 32'(ifa.out_valid), 32'd0);
      tick();
    end
    check("stall_out_valid", 32'(ifa.out_valid), 32'd1);

    // reset mid-permutation at round 7
    ifa.out_ack = 1'b1;
    tick();
    ifa.out_ack = 1'b0;
    ifa.in_valid = 1'b1;
    settle();
    check("mid_load", 32'(ifa.load), 32'd1);
    tick();
    ifa.in_valid = 1'b0;
    ifa.out_ack = 1'b1;
    settle();
    for (int i = 0; i < 7; i++) tick();
    check("mid_idx", 32'(ifa.round_idx), 32'd7);
    check("mid_ack_ignored_busy", 32'(ifa.busy), 32'd1);
    ifa.out_ack = 1'b0;
    reset = 1'b1;
    settle();
    check("mid_rst_round_en", 32'(ifa.round_en), 32'd0);
    tick();
    reset = 1'b0;
    settle();
    check("mid_rst_state", 32'(state_a), 32'(S_IDLE));
    check("mid_rst_onehot", 32'(ifa.round_onehot), 32'd0);
    check("mid_rst_idx", 32'(ifa.round_idx), 32'd0);
    check("mid_rst_busy", 32'(ifa.busy), 32'd0);
    check("mid_rst_out_valid", 32'(ifa.out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(ifa.in_ready), 32'd1);

    // back-to-back: loads at T and T+26, i.e. a 27-cycle span counted inclusively
    ifa.in_valid = 1'b1;
    ifa.out_ack = 1'b1;
    for (int c = 0; c < 85; c++) begin
      settle();
      if (ifa.load) load_cyc.push_back(c);
      tick();
    end
    ifa.in_valid = 1'b0;
    ifa.out_ack = 1'b0;
    check("b2b_num_loads", 32'(load_cyc.size()), 32'd4);
    if (load_cyc.size() >= 3) begin
      check("b2b_period_1", 32'(load_cyc[1] - load_cyc[0] + 1), 32'd27);
      check("b2b_period_2", 32'(load_cyc[2] - load_cyc[1] + 1), 32'd27);
    end else begin
      check("b2b_loads_seen", 32'(load_cyc.size()), 32'd3);
    end

    // NROUNDS = 1 instance
    ifb.in_valid = 1'b1;
    settle();
    check("n1_load", 32'(ifb.load), 32'd1);
    tick();
    ifb.in_valid = 1'b0;
    settle();
    check("n1_round_en", 32'(ifb.round_en), 32'd1);
    check("n1_onehot", 32'(ifb.round_onehot), 32'h000001);
    check("n1_idx", 32'(ifb.round_idx), 32'd0);
    tick();
    check("n1_round_en_off", 32'(ifb.round_en), 32'd0);
    check("n1_out_valid", 32'(ifb.out_valid), 32'd1);
    check("n1_onehot_clr", 32'(ifb.round_onehot), 32'd0);
    check("n1_state", 32'(state_b), 32'(S_DONE));
    ifb.out_ack = 1'b1;
    tick();
    ifb.out_ack = 1'b0;
    settle();
    check("n1_back_idle", 32'(ifb.in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
